// File: rtl/ex_div_seq_if.sv
// ex_div_seq_if: request/response bundle between the EX stage and the
// iterative divider sequencer.
//
// Signals (EX side drives the request group, divider drives the response group):
//   id2ex_div_req    EX holds a divide-class instruction
//   id2ex_div_op     0=DIV, 1=DIVU, 2=REM, 3=REMU
//   op1_forwarded    dividend after forwarding
//   op2_forwarded    divisor after forwarding
//   id2ex_reg_waddr  destination register of the divide
//   ex_flush         kill the EX-stage instruction
//   div_stall        hold IF/ID/EX pipeline registers
//   div_done         one-cycle result valid
//   div_result       quotient or remainder
//   div_waddr        destination register latched at accept
//
// Modports: master = EX stage, slave = divider.
interface ex_div_seq_if #(
  parameter int XLEN = 32
);
  logic            id2ex_div_req;
  logic [1:0]      id2ex_div_op;
  logic [XLEN-1:0] op1_forwarded;
  logic [XLEN-1:0] op2_forwarded;
  logic [4:0]      id2ex_reg_waddr;
  logic            ex_flush;
  logic            div_stall;
  logic            div_done;
  logic [XLEN-1:0] div_result;
  logic [4:0]      div_waddr;

  modport master (
    output id2ex_div_req, id2ex_div_op, op1_forwarded, op2_forwarded,
           id2ex_reg_waddr, ex_flush,
    input  div_stall, div_done, div_result, div_waddr
  );

  modport slave (
    input  id2ex_div_req, id2ex_div_op, op1_forwarded, op2_forwarded,
           id2ex_reg_waddr, ex_flush,
    output div_stall, div_done, div_result, div_waddr
  );
endinterface

// File: rtl/ex_div_seq.sv
// ex_div_seq: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU,
// attached to the EX stage. Operands are converted to magnitudes at accept,
// one quotient bit is produced per CALC cycle, and sign correction plus
// quotient/remainder selection happen in the DONE state.
//
// Ports:
//   clk   core clock
//   rst   asynchronous, active-low reset
//   bus   ex_div_seq_if.slave (request from EX, stall/done/result back)
//
// Optional feature: define DIV_EARLY_OUT_EN to finish in two cycles when
// |dividend| < |divisor| (result is identical, only latency changes).
module ex_div_seq #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  ex_div_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      dwaddr_q, dwaddr_d;

  function automatic logic [XLEN-1:0] neg2(input logic [XLEN-1:0] v);
    return (~v) + XLEN'(1);
  endfunction

  // Operand conditioning for the accept decision
  logic            accept;
  logic            is_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            ovf;

  assign accept    = bus.id2ex_div_req & ~bus.ex_flush;
  assign is_signed = ~bus.id2ex_div_op[0];
  assign a_neg     = is_signed & bus.op1_forwarded[XLEN-1];
  assign b_neg     = is_signed & bus.op2_forwarded[XLEN-1];
  assign a_mag     = a_neg ? neg2(bus.op1_forwarded) : bus.op1_forwarded;
  assign b_mag     = b_neg ? neg2(bus.op2_forwarded) : bus.op2_forwarded;
  assign ovf       = is_signed && (bus.op1_forwarded == INT_MIN) &&
                     (bus.op2_forwarded == '1);

  // Restoring step: rem is widened by one bit so the shifted-out MSB
  // participates in the compare. When the subtract is taken the true
  // difference is below the divisor, so the low XLEN bits are exact.
  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] diff;

  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign ge      = (shifted >= {1'b0, dvs_q});
  assign diff    = shifted[XLEN-1:0] - dvs_q;

  // Final sign correction; sign flags are already zero for unsigned ops
  // and for the special cases whose results are stored pre-corrected.
  logic [XLEN-1:0] q_fix, r_fix;
  assign q_fix = qneg_q ? neg2(quo_q) : quo_q;
  assign r_fix = rneg_q ? neg2(rem_q) : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    waddr_d  = waddr_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    done_d   = 1'b0;
    result_d = result_q;
    dwaddr_d = dwaddr_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = bus.id2ex_div_op;
          waddr_d = bus.id2ex_reg_waddr;
          dvs_d   = b_mag;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          cnt_d   = '0;
          if (bus.op2_forwarded == '0) begin
            // Divide by zero: architectural results, no sign fix-up
            quo_d   = '1;
            rem_d   = bus.op1_forwarded;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = S_DONE;
          end else if (ovf) begin
            quo_d   = INT_MIN;
            rem_d   = '0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = S_DONE;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (a_mag < b_mag) begin
            quo_d   = '0;
            rem_d   = a_mag;
            state_d = S_DONE;
          end
`endif
          else begin
            quo_d   = a_mag;
            rem_d   = '0;
            cnt_d   = CNT_W'(XLEN - 1);
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (bus.ex_flush) begin
          state_d = S_IDLE;
        end else begin
          quo_d = {quo_q[XLEN-2:0], ge};
          rem_d = ge ? diff : shifted[XLEN-1:0];
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        if (!bus.ex_flush) begin
          done_d   = 1'b1;
          result_d = op_q[1] ? r_fix : q_fix;
          dwaddr_d = waddr_q;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      waddr_q  <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      dwaddr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      waddr_q  <= waddr_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      done_q   <= done_d;
      result_q <= result_d;
      dwaddr_q <= dwaddr_d;
    end
  end

  // Stall covers the accept cycle too, so EX holds until div_done
  assign bus.div_stall  = ((state_q == S_IDLE) && accept) ||
                          (state_q == S_CALC) || (state_q == S_DONE);
  assign bus.div_done   = done_q;
  assign bus.div_result = result_q;
  assign bus.div_waddr  = dwaddr_q;

endmodule

// File: doc/ex_div_seq.md
Name: ex_div_seq

Overview:
- Iterative radix-2 divider sequencer attached to the EX stage; executes RV32M DIV/DIVU/REM/REMU.
- Takes forwarded operands from EX, holds the pipeline with a stall while iterating, and returns the result with its destination register.
- Owns the state machine, the iteration counter, the sign handling and the shift/subtract datapath.

Parameters:
- XLEN, 32, operand/result width; iteration counter width is clog2(XLEN).

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-low reset
- id2ex_div_req  input  1  EX holds a divide-class instruction
- id2ex_div_op  input  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- op1_forwarded  input  XLEN  dividend, after forwarding
- op2_forwarded  input  XLEN  divisor, after forwarding
- id2ex_reg_waddr  input  5  destination register
- ex_flush  input  1  kill the EX-stage instruction (branch taken or trap)
- div_stall  output  1  hold the IF/ID/EX pipeline registers
- div_done  output  1  one-cycle result valid
- div_result  output  XLEN  quotient or remainder
- div_waddr  output  5  destination register latched at accept

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, div_done=0, div_result=0, div_waddr=0. Internal regs are also cleared.
- States:
  - IDLE: accept when id2ex_div_req=1 and ex_flush=0. On accept, latch op, waddr, |dividend|, |divisor| (magnitudes only for signed ops), quotient sign = sign(op1) xor sign(op2), remainder sign = sign(op1).
    - divisor==0 -> DONE directly: quotient=all ones, remainder=op1.
    - Signed op with op1=0x80000000 and op2=0xFFFFFFFF -> DONE directly: quotient=0x80000000, remainder=0.
    - Otherwise -> CALC with counter=XLEN-1.
  - CALC: one restoring step per cycle.
    - Shift {rem,quo} left by 1.
    - If rem_shifted >= divisor: subtract and set quo bit0.
    - Decrement counter; at counter==0 after the step -> DONE. This gives exactly XLEN CALC cycles.
  - DONE: negate the quotient if its sign is 1 and the op is signed; negate the remainder likewise. Select quotient for DIV/DIVU and remainder for REM/REMU. Register the result. Next state is IDLE.
- div_done=1 for exactly the one cycle after the DONE state, together with div_result and div_waddr. div_result holds that value until the next completion.
- div_stall, combinational:
  - 1 in IDLE when the accept condition is true.
  - 1 in CALC.
  - 1 in DONE.
  - 0 otherwise.
  - The pipeline advances on the cycle div_done=1, so the same instruction is never re-accepted.
- Latency, accept cycle = T:
  - Normal path: CALC T+1..T+32, DONE T+33, div_done at T+34.
  - Special cases: DONE T+1, div_done at T+2.
- ex_flush:
  - In CALC or DONE: return to IDLE next cycle; no div_done; div_result unchanged.
  - In IDLE: blocks accept.
- A new request in the cycle div_done=1 is accepted (back-to-back, no bubble).
- Arithmetic: rem datapath is XLEN+1 bits wide for the compare/subtract. Negation is two's complement at XLEN width.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in IDLE, if |dividend| < |divisor| (unsigned compare of magnitudes, divisor nonzero), go to DONE directly with quotient=0 and remainder=|dividend|. Sign correction is applied as usual, so div_done arrives at T+2.
- Not defined: such operations take the full XLEN-cycle path. Results are identical either way; only latency differs.

Test Plan:
- DIVU 100/7, accept at T -> div_stall high T..T+33; div_done at T+34 with result 14 and waddr as latched.
- REM -7 % 2 (0xFFFFFFF9, 2) -> result 0xFFFFFFFF (-1). DIV of the same operands -> 0xFFFFFFFD (-3).
- DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with div_done at T+2. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, and REM of the same -> 0, both at T+2.
- Start DIVU 1000/3, assert ex_flush at T+10 -> no div_done; state IDLE at T+11; a following DIVU 9/3 returns 3 with normal latency.
- Drive rst low at T+5 of an operation -> all outputs 0 immediately; after release, DIV -20/6 returns 0xFFFFFFFD.
- DIVU 3/10:
  - With DIV_EARLY_OUT_EN -> result 0 at T+2.
  - Without it -> result 0 at T+34.
  - Back-to-back REMU 3/10 accepted on the div_done cycle -> result 3.
